ac_rle_sequencer: RTL and testbench
===================================

# ac_rle_sequencer

Run-length scheduler for the JPEG AC entropy path. Accepts the 63 quantized AC coefficients of an 8x8 block in zigzag order and counts zero runs. For each symbol it drives the (run, size) pair into the Huffman code lookup and emits the code plus amplitude bits, one symbol per handshake, to the bit packer. It inserts ZRL (15,0) for every 16 pending zeros before a nonzero coefficient and EOB (0,0) when a block ends in zeros.

## Interface
Parameters:
- COEF_W, 12, signed coefficient width (two's complement)

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous, active-high reset
- coef_in  in  COEF_W  signed AC coefficient, zigzag index 1..63
- coef_valid_in  in  1  coef_in valid
- coef_ready_out  out  1  block accepts coef_in this cycle
- lut_run_out  out  8  run to Huffman LUT `value` input (0..15, upper bits 0)
- lut_size_out  out  8  size to Huffman LUT `count` input (0..10, upper bits 0)
- lut_code_in  in  16  LUT code, right-aligned
- lut_len_in  in  5  code length from companion length ROM (2..16)
- sym_code_out  out  16  Huffman code, right-aligned
- sym_len_out  out  5  valid bits in sym_code_out
- amp_bits_out  out  10  amplitude bits, right-aligned
- amp_len_out  out  4  valid bits in amp_bits_out (0 for ZRL/EOB)
- sym_valid_out  out  1  symbol valid
- sym_ready_in  in  1  downstream accepts symbol
- block_done_out  out  1  one-cycle pulse when last symbol of a block transfers

## Operation
- Internal index counter idx (1..63); zero_run counter (0..62); a held nonzero coefficient register.
- States: ACCEPT, ZRL, SYM, EOB.
- ACCEPT: coef_ready_out = !sym_valid_out || sym_ready_in. On transfer:
  - Zero coefficient: zero_run++. If idx==63, go to EOB.
  - Nonzero coefficient: hold it. If zero_run>=16, go to ZRL; otherwise load the symbol (run=zero_run) and stay in ACCEPT (or return to ACCEPT at idx 63).
  - idx++; it wraps to 1 after 63.
- ZRL: drive (15,0) and load ZRL symbol; zero_run -= 16 on its transfer. Repeat while zero_run>=16, then go to SYM.
- SYM: load the held coefficient's symbol, zero_run=0, then go to ACCEPT.
- EOB: drive (0,0) and load EOB symbol. On transfer, pulse block_done_out, zero_run=0, go to ACCEPT.
- A block whose idx 63 is nonzero emits no EOB. block_done_out pulses with that final symbol's transfer.
- Trailing zeros never produce ZRL; only EOB.
- Size/amplitude:
  - coef is saturated to [-1023, 1023].
  - size = bit length of |coef| (1..10).
  - Positive: amp = coef[size-1:0].
  - Negative: amp = (coef-1)[size-1:0].
  - amp_bits_out upper bits are zero.
- coef_ready_out is low in ZRL/SYM/EOB.

## Timing
- Reset values: coef_ready_out=0 during reset (1 after release), sym_valid_out=0, block_done_out=0, all data outputs 0, idx=1, zero_run=0, state ACCEPT.
- LUT is combinational. lut_*_out are driven in the cycle a symbol is loaded, and lut_code_in/lut_len_in are registered that same edge.
- Nonzero coef with zero_run<16 accepted at edge N: sym_valid_out high after edge N.
- Each ZRL adds one symbol slot, i.e. at least one cycle.
- Output stall rule: while sym_valid_out && !sym_ready_in, every sym_*/amp_* output holds stable and no new symbol loads.
- Zero coefficients can be accepted back-to-back at 1 per cycle while no symbol is stalled.
- Reset mid-block discards the partial block. The next accepted coefficient is idx 1.

## Configuration
- AC_RLE_STATS_EN defined:
  - Adds port sym_count_out (out, 7 bits): number of symbols (including ZRL/EOB) in the last completed block.
  - Updated on the block_done_out cycle; reset value 0.
- Undefined: the port and its counter are absent; all other behaviour is identical.

## Test plan
- All 63 coefs 0, sym_ready_in=1 -> exactly one symbol: EOB, LUT driven (0,0), amp_len 0, block_done_out pulse.
- idx1=+5, rest 0 -> symbol (0,3) amp=101 len 3, then EOB.
- idx1=-5 -> (0,3) amp=010.
- 20 zeros then +1 at idx 21, rest 0 -> ZRL (15,0), then (4,1) amp=1, then EOB; 3 symbols.
- All 63 coefs = -1 -> 63 symbols (0,1) amp=0, no EOB. block_done_out on the 63rd transfer.
- coef +2000 -> saturates to 1023: (run,10), amp=1111111111.
- sym_ready_in held low for 5 cycles mid-block -> outputs stable, coef_ready_out low, no loss.
- rst_in asserted at idx 30 -> outputs 0; the next block restarts at idx 1.

Source files
------------

// File: rtl/ac_rle_sequencer.sv
// JPEG AC run-length sequencer: counts zero runs and inserts ZRL/EOB. Emits one (code, amplitude) symbol per handshake.
// Optional build macro AC_RLE_STATS_EN adds sym_count_out, the symbol count of the last completed block.
module ac_rle_sequencer #(
    parameter int COEF_W = 12
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic signed [COEF_W-1:0] coef_in,
    input  logic                     coef_valid_in,
    output logic                     coef_ready_out,
    output logic [7:0]               lut_run_out,
    output logic [7:0]               lut_size_out,
    input  logic [15:0]              lut_code_in,
    input  logic [4:0]               lut_len_in,
    output logic [15:0]              sym_code_out,
    output logic [4:0]               sym_len_out,
    output logic [9:0]               amp_bits_out,
    output logic [3:0]               amp_len_out,
    output logic                     sym_valid_out,
    input  logic                     sym_ready_in,
    output logic                     block_done_out
`ifdef AC_RLE_STATS_EN
    ,
    output logic [6:0]               sym_count_out
`endif
);

    typedef enum logic [1:0] {ST_ACCEPT, ST_ZRL, ST_SYM, ST_EOB} state_t;

    // Saturation bounds assume COEF_W >= 11 so that +/-1023 is representable.
    localparam logic signed [COEF_W-1:0] SAT_POS = COEF_W'(1023);
    localparam logic signed [COEF_W-1:0] SAT_NEG = -SAT_POS;

    state_t                   r_state;
    logic [5:0]               r_idx;
    logic [5:0]               r_zero_run;
    logic signed [COEF_W-1:0] r_held_coef;
    logic                     r_held_last;
    logic [15:0]              r_sym_code;
    logic [4:0]               r_sym_len;
    logic [9:0]               r_amp_bits;
    logic [3:0]               r_amp_len;
    logic                     r_sym_valid;
    logic                     r_sym_last;

    logic                     w_out_free;
    logic                     w_accept;
    logic                     w_coef_nz;
    logic                     w_load;
    logic                     w_last;
    logic                     w_is_data;
    logic signed [COEF_W-1:0] w_sym_coef;
    logic signed [COEF_W-1:0] w_sat;
    logic [9:0]               w_mag;
    logic [9:0]               w_amp_mask;
    logic [9:0]               w_amp;
    logic [3:0]               w_size;
    logic [3:0]               w_lut_run;
    logic [3:0]               w_lut_size;

    assign w_out_free     = !r_sym_valid || sym_ready_in;
    assign coef_ready_out = !rst_in && (r_state == ST_ACCEPT) && w_out_free;
    assign w_accept       = coef_valid_in && coef_ready_out;
    assign w_coef_nz      = (coef_in != '0);
    assign w_sym_coef     = (r_state == ST_SYM) ? r_held_coef : coef_in;

    // Negative amplitude is the low bits of (coef - 1), i.e. the one's complement of |coef|.
    always_comb begin : size_amp
        w_sat = w_sym_coef;
        if (w_sym_coef > SAT_POS)
            w_sat = SAT_POS;
        else if (w_sym_coef < SAT_NEG)
            w_sat = SAT_NEG;
        w_mag  = w_sat[COEF_W-1] ? 10'(-w_sat) : 10'(w_sat);
        w_size = '0;
        for (int b = 0; b < 10; b++)
            if (w_mag[b]) w_size = 4'(b + 1);
        w_amp_mask = 10'((11'd1 << w_size) - 11'd1);
        w_amp      = (w_sat[COEF_W-1] ? (w_sat[9:0] - 10'd1) : w_sat[9:0]) & w_amp_mask;
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin : load_select
        w_load     = 1'b0;
        w_lut_run  = '0;
        w_lut_size = '0;
        w_last     = 1'b0;
        w_is_data  = 1'b0;
        case (r_state)
            ST_ACCEPT: if (w_accept && w_coef_nz && (r_zero_run < 6'd16)) begin
                w_load     = 1'b1;
                w_lut_run  = r_zero_run[3:0];
                w_lut_size = w_size;
                w_last     = (r_idx == 6'd63);
                w_is_data  = 1'b1;
            end
            ST_ZRL: if (w_out_free) begin
                w_load    = 1'b1;
                w_lut_run = 4'd15;
            end
            ST_SYM: if (w_out_free) begin
                w_load     = 1'b1;
                w_lut_run  = r_zero_run[3:0];
                w_lut_size = w_size;
                w_last     = r_held_last;
                w_is_data  = 1'b1;
            end
            ST_EOB: if (w_out_free) begin
                w_load = 1'b1;
                w_last = 1'b1;
            end
            default: w_load = 1'b0;
        endcase
    end

    assign lut_run_out  = {4'b0, w_lut_run};
    assign lut_size_out = {4'b0, w_lut_size};

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= ST_ACCEPT;
            r_idx       <= 6'd1;
            r_zero_run  <= '0;
            r_held_coef <= '0;
            r_held_last <= 1'b0;
            r_sym_code  <= '0;
            r_sym_len   <= '0;
            r_amp_bits  <= '0;
            r_amp_len   <= '0;
            r_sym_valid <= 1'b0;
            r_sym_last  <= 1'b0;
        end else begin
            if (w_load) begin
                r_sym_valid <= 1'b1;
                r_sym_code  <= lut_code_in;
                r_sym_len   <= lut_len_in;
                r_amp_bits  <= w_is_data ? w_amp : 10'd0;
                r_amp_len   <= w_is_data ? w_lut_size : 4'd0;
                r_sym_last  <= w_last;
            end else if (sym_ready_in) begin
                r_sym_valid <= 1'b0;
            end

            if (w_accept)
                r_idx <= (r_idx == 6'd63) ? 6'd1 : r_idx + 6'd1;

            case (r_state)
                ST_ACCEPT: if (w_accept) begin
                    if (!w_coef_nz) begin
                        r_zero_run <= r_zero_run + 6'd1;
                        if (r_idx == 6'd63) r_state <= ST_EOB;
                    end else begin
                        r_held_coef <= coef_in;
                        r_held_last <= (r_idx == 6'd63);
                        if (r_zero_run >= 6'd16)
                            r_state <= ST_ZRL;
                        else
                            r_zero_run <= '0;
                    end
                end
                ST_ZRL: if (w_out_free) begin
                    r_zero_run <= r_zero_run - 6'd16;
                    if (r_zero_run < 6'd32) r_state <= ST_SYM;
                end
                ST_SYM, ST_EOB: if (w_out_free) begin
                    r_zero_run <= '0;
                    r_state    <= ST_ACCEPT;
                end
                default: r_state <= ST_ACCEPT;
            endcase
        end
    end

    assign sym_code_out   = r_sym_code;
    assign sym_len_out    = r_sym_len;
    assign amp_bits_out   = r_amp_bits;
    assign amp_len_out    = r_amp_len;
    assign sym_valid_out  = r_sym_valid;
    assign block_done_out = r_sym_valid && r_sym_last && sym_ready_in;

`ifdef AC_RLE_STATS_EN
    logic [6:0] r_blk_syms;
    logic [6:0] r_last_cnt;
    logic [6:0] r_sym_count;

    // The final symbol's count is parked until it actually transfers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_blk_syms  <= '0;
            r_last_cnt  <= '0;
            r_sym_count <= '0;
        end else begin
            if (w_load) begin
                if (w_last) begin
                    r_blk_syms <= '0;
                    r_last_cnt <= r_blk_syms + 7'd1;
                end else begin
                    r_blk_syms <= r_blk_syms + 7'd1;
                end
            end
            if (block_done_out)
                r_sym_count <= r_last_cnt;
        end
    end

    assign sym_count_out = r_sym_count;
`endif

endmodule

// File: tb/tb_ac_rle_sequencer.sv
// Self-checking bench for ac_rle_sequencer: directed and random blocks against a queue-based symbol model.
module tb_ac_rle_sequencer;

    localparam int COEF_W = 12;
    localparam int BUDGET = 2000;

    typedef struct {
        logic [15:0] code;
        logic [4:0]  len;
        logic [9:0]  amp;
        logic [3:0]  alen;
        logic        last;
    } exp_t;

    logic                     clk_in = 1'b0;
    logic                     rst_in;
    logic signed [COEF_W-1:0] coef_in;
    logic                     coef_valid_in;
    logic                     coef_ready_out;
    logic [7:0]               lut_run_out;
    logic [7:0]               lut_size_out;
    logic [15:0]              lut_code_in;
    logic [4:0]               lut_len_in;
    logic [15:0]              sym_code_out;
    logic [4:0]               sym_len_out;
    logic [9:0]               amp_bits_out;
    logic [3:0]               amp_len_out;
    logic                     sym_valid_out;
    logic                     sym_ready_in;
    logic                     block_done_out;
`ifdef AC_RLE_STATS_EN
    logic [6:0]               sym_count_out;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic signed [COEF_W-1:0] blk [1:63];
    exp_t                     exp_q [$];

    always #5 clk_in = ~clk_in;

    // Stand-in Huffman table: any injective-enough map of (run, size) serves.
    function automatic logic [15:0] lut_code(input logic [7:0] r, input logic [7:0] s);
        return 16'((int'(r) * 16 + int'(s)) * 97 + 11);
    endfunction

    function automatic logic [4:0] lut_len(input logic [7:0] r, input logic [7:0] s);
        return 5'(2 + (int'(r) * 3 + int'(s)) % 15);
    endfunction

    assign lut_code_in = lut_code(lut_run_out, lut_size_out);
    assign lut_len_in  = lut_len(lut_run_out, lut_size_out);

    ac_rle_sequencer #(.COEF_W(COEF_W)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .coef_in        (coef_in),
        .coef_valid_in  (coef_valid_in),
        .coef_ready_out (coef_ready_out),
        .lut_run_out    (lut_run_out),
        .lut_size_out   (lut_size_out),
        .lut_code_in    (lut_code_in),
        .lut_len_in     (lut_len_in),
        .sym_code_out   (sym_code_out),
        .sym_len_out    (sym_len_out),
        .amp_bits_out   (amp_bits_out),
        .amp_len_out    (amp_len_out),
        .sym_valid_out  (sym_valid_out),
        .sym_ready_in   (sym_ready_in),
        .block_done_out (block_done_out)
`ifdef AC_RLE_STATS_EN
        ,
        .sym_count_out  (sym_count_out)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_sym(input int run, input int v, input bit is_data);
        int   sat, mag, s, a;
        exp_t e;
        s = 0;
        a = 0;
        if (is_data) begin
            sat = (v > 1023) ? 1023 : ((v < -1023) ? -1023 : v);
            mag = (sat < 0) ? -sat : sat;
            while ((1 << s) <= mag) s++;
            a = (sat > 0) ? sat : sat + (1 << s) - 1;
        end
        e.code = lut_code(8'(run), 8'(s));
        e.len  = lut_len(8'(run), 8'(s));
        e.amp  = 10'(a);
        e.alen = 4'(s);
        e.last = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic build_expected();
        int   run, last_nz;
        exp_t t;
        run     = 0;
        last_nz = 0;
        exp_q.delete();
        for (int i = 1; i <= 63; i++)
            if (blk[i] != 0) last_nz = i;
        for (int i = 1; i <= 63; i++) begin
            if (blk[i] == 0) begin
                run++;
            end else begin
                while (run >= 16) begin
                    push_sym(15, 0, 1'b0);
                    run -= 16;
                end
                push_sym(run, int'(blk[i]), 1'b1);
                run = 0;
            end
        end
        if (last_nz < 63) push_sym(0, 0, 1'b0);
        t = exp_q.pop_back();
        t.last = 1'b1;
        exp_q.push_back(t);
    endtask

    task automatic clear_blk();
        for (int i = 1; i <= 63; i++) blk[i] = '0;
    endtask

    task automatic random_blk(input int zero_pct);
        int v;
        for (int i = 1; i <= 63; i++) begin
            v = int'($urandom_range(0, 4000)) - 2000;
            blk[i] = ($urandom_range(0, 99) < zero_pct) ? '0 : COEF_W'(v);
        end
    endtask

    // mode 0: always ready; 1: random ready and valid gaps; 2: ready low for cycles 10..14.
    task automatic run_block(input int mode, input int abort_at, output int n_syms);
        int   ci, cyc, zeros, exp_total;
        bit   expect_valid;
        exp_t e;
        ci           = 1;
        cyc          = 0;
        zeros        = 0;
        expect_valid = 1'b0;
        n_syms       = 0;
        build_expected();
        exp_total = exp_q.size();
        while ((ci <= 63 || exp_q.size() > 0) && cyc < BUDGET) begin
            @(negedge clk_in);
            if (expect_valid) chk("load_latency", sym_valid_out, 1);
            case (mode)
                1:       sym_ready_in = ($urandom_range(0, 3) != 0);
                2:       sym_ready_in = !(cyc >= 10 && cyc < 15);
                default: sym_ready_in = 1'b1;
            endcase
            coef_valid_in = (ci <= 63) && (mode != 1 || $urandom_range(0, 4) != 0);
            coef_in       = coef_valid_in ? blk[ci] : COEF_W'($urandom);
            #1;
            if (sym_valid_out) begin
                if (exp_q.size() == 0) begin
                    chk("extra_symbol", sym_valid_out, 0);
                end else begin
                    e = exp_q[0];
                    chk("sym_code", sym_code_out, e.code);
                    chk("sym_len", sym_len_out, e.len);
                    chk("amp_bits", amp_bits_out, e.amp);
                    chk("amp_len", amp_len_out, e.alen);
                    if (sym_ready_in) begin
                        chk("block_done", block_done_out, e.last);
                        void'(exp_q.pop_front());
                        n_syms++;
                    end
                end
                if (!sym_ready_in) chk("stall_coef_ready", coef_ready_out, 0);
            end
            if (!(sym_valid_out && sym_ready_in)) chk("block_done_idle", block_done_out, 0);
            expect_valid = 1'b0;
            if (coef_valid_in && coef_ready_out) begin
                if (blk[ci] != 0) begin
                    expect_valid = (zeros < 16);
                    zeros        = 0;
                end else begin
                    zeros++;
                end
                ci++;
                if (abort_at > 0 && ci > abort_at) break;
            end
            cyc++;
        end
        if (abort_at == 0) begin
            chk("block_in_budget", cyc < BUDGET, 1);
            chk("symbol_total", n_syms, exp_total);
            @(negedge clk_in);
            coef_valid_in = 1'b0;
            sym_ready_in  = 1'b1;
`ifdef AC_RLE_STATS_EN
            chk("sym_count", sym_count_out, exp_total);
`endif
        end
    endtask

    initial begin
        int n;
        rst_in        = 1'b1;
        coef_valid_in = 1'b0;
        coef_in       = '0;
        sym_ready_in  = 1'b1;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        #1;
        chk("rst_coef_ready", coef_ready_out, 0);
        chk("rst_sym_valid", sym_valid_out, 0);
        chk("rst_block_done", block_done_out, 0);
        chk("rst_sym_code", sym_code_out, 0);
        chk("rst_sym_len", sym_len_out, 0);
        chk("rst_amp_bits", amp_bits_out, 0);
        chk("rst_amp_len", amp_len_out, 0);
        chk("rst_lut_run", lut_run_out, 0);
        chk("rst_lut_size", lut_size_out, 0);
        rst_in = 1'b0;
        #1;
        chk("ready_after_reset", coef_ready_out, 1);

        clear_blk();
        run_block(0, 0, n);
        chk("all_zero_syms", n, 1);

        clear_blk();
        blk[1] = 12'sd5;
        run_block(0, 0, n);
        chk("pos5_syms", n, 2);

        clear_blk();
        blk[1] = -12'sd5;
        run_block(0, 0, n);
        chk("neg5_syms", n, 2);

        clear_blk();
        blk[21] = 12'sd1;
        run_block(0, 0, n);
        chk("zrl_block_syms", n, 3);

        for (int i = 1; i <= 63; i++) blk[i] = -12'sd1;
        run_block(0, 0, n);
        chk("all_neg1_syms", n, 63);

        clear_blk();
        blk[4]  = 12'sd2000;
        blk[5]  = -12'sd2000;
        blk[40] = -12'sd1023;
        blk[63] = 12'sd1024;
        run_block(0, 0, n);

        clear_blk();
        blk[50] = -12'sd77;
        blk[63] = 12'sd3;
        run_block(1, 0, n);

        for (int i = 1; i <= 63; i++) blk[i] = (i % 2 == 1) ? COEF_W'(i) : COEF_W'(-3 * i);
        run_block(2, 0, n);

        random_blk(40);
        run_block(0, 30, n);
        @(posedge clk_in);
        #2;
        rst_in = 1'b1;
        #1;
        chk("midrst_sym_valid", sym_valid_out, 0);
        chk("midrst_coef_ready", coef_ready_out, 0);
        chk("midrst_sym_code", sym_code_out, 0);
        chk("midrst_amp_len", amp_len_out, 0);
        chk("midrst_block_done", block_done_out, 0);
        coef_valid_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
        exp_q.delete();
        clear_blk();
        blk[1]  = 12'sd7;
        blk[30] = -12'sd300;
        run_block(1, 0, n);
        chk("post_rst_syms", n, 4);

        for (int b = 0; b < 10; b++) begin
            random_blk(int'($urandom_range(50, 97)));
            run_block(1, 0, n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
